// File: rtl/rtc_digit_encoder.sv
// rtc_digit_encoder: turns two glyph-tile selections (tens, then units)
// into one packed, range-checked BCD byte for the RTC write controller.
//
// Ports:
//   clk            system clock, all state on the rising edge
//   reset          asynchronous active-high reset
//   enable         block enable; when low, keys are ignored
//   key_valid      single-cycle strobe qualifying address_in/sel_address_in
//   address_in     glyph column within the selected bank
//   sel_address_in glyph bank select
//   clear          aborts the entry in progress (wins over keys/handshake)
//   bcd_out        packed BCD result {tens, units}, held outside OUT
//   bcd_valid      result available, held until bcd_ready
//   bcd_ready      consumer accept
//   tens_pending   tens digit held, waiting for the units digit
//   digit_error    one-cycle pulse on a rejected entry
//
// Optional feature: define RTC_ENCODER_TIMEOUT_EN to abandon a tens digit
// when no units key arrives within TIMEOUT_CYCLES cycles.

module rtc_digit_encoder #(
    parameter logic [7:0] MAX_VALUE      = 8'h59,
    parameter int         TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       key_valid,
    input  logic [1:0] address_in,
    input  logic [3:0] sel_address_in,
    input  logic       clear,
    output logic [7:0] bcd_out,
    output logic       bcd_valid,
    input  logic       bcd_ready,
    output logic       tens_pending,
    output logic       digit_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TENS = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] tens;

    logic       key_ok;
    logic [3:0] key_digit;
    logic [7:0] packed_val;
    logic       in_range;
    logic       key_take;

    // Bad TIMEOUT_CYCLES would give a zero-width counter.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("rtc_digit_encoder: TIMEOUT_CYCLES must be at least 2");
    end

`ifdef RTC_ENCODER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit;

    assign tmo_hit = (tmo_cnt == LAST);
`endif

    // Glyph tile -> digit.  Bank 4 holds 0-3, bank 5 holds 4-7 and the
    // first two columns of bank 6 hold 8 and 9; everything else is blank.
    always_comb begin
        key_ok    = 1'b0;
        key_digit = 4'd0;
        unique case (1'b1)
            (sel_address_in == 4'd4): begin
                key_ok    = 1'b1;
                key_digit = {2'b00, address_in};
            end
            (sel_address_in == 4'd5): begin
                key_ok    = 1'b1;
                key_digit = {2'b01, address_in};
            end
            (sel_address_in == 4'd6) && !address_in[1]: begin
                key_ok    = 1'b1;
                key_digit = {3'b100, address_in[0]};
            end
            default: begin
                key_ok    = 1'b0;
                key_digit = 4'd0;
            end
        endcase
    end

    assign packed_val = {tens, key_digit};
    assign in_range   = (packed_val <= MAX_VALUE);
    assign key_take   = enable && key_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            tens         <= 4'd0;
            bcd_out      <= 8'h00;
            bcd_valid    <= 1'b0;
            tens_pending <= 1'b0;
            digit_error  <= 1'b0;
`ifdef RTC_ENCODER_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            digit_error <= 1'b0;
`ifdef RTC_ENCODER_TIMEOUT_EN
            if (state == TENS) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
            if (clear) begin
                // Silent abort: no error, result (if any) withdrawn.
                state        <= IDLE;
                bcd_valid    <= 1'b0;
                tens_pending <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (key_take) begin
                            if (key_ok) begin
                                tens         <= key_digit;
                                state        <= TENS;
                                tens_pending <= 1'b1;
`ifdef RTC_ENCODER_TIMEOUT_EN
                                tmo_cnt      <= '0;
`endif
                            end else begin
                                digit_error <= 1'b1;
                            end
                        end
                    end
                    TENS: begin
                        if (!enable) begin
                            state        <= IDLE;
                            tens_pending <= 1'b0;
                        end else if (key_valid) begin
                            // Units key beats a coincident timeout.
                            tens_pending <= 1'b0;
                            if (key_ok && in_range) begin
                                bcd_out   <= packed_val;
                                bcd_valid <= 1'b1;
                                state     <= OUT;
                            end else begin
                                digit_error <= 1'b1;
                                state       <= IDLE;
                            end
`ifdef RTC_ENCODER_TIMEOUT_EN
                        end else if (tmo_hit) begin
                            tens_pending <= 1'b0;
                            digit_error  <= 1'b1;
                            state        <= IDLE;
`endif
                        end
                    end
                    OUT: begin
                        // Keys are ignored until the result is taken.
                        if (bcd_ready) begin
                            bcd_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    default: begin
                        state        <= IDLE;
                        bcd_valid    <= 1'b0;
                        tens_pending <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
